pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
// - Producer of the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem, mem_wb.
// - Merges per-stage stall requests; turns EX-resolved jumps/branches into a PC redirect plus a flush.
// - Holds a redirect pending while the fetch stage is stalled and issues it exactly once on release.
// - Sits beside the pipeline registers; all pipeline state is owned by those registers, not here.
// PARAMETERS
// - ADDR_W  32  width of redirect target
// - CNT_W   32  width of statistics counters (STALL_STATS_EN only)
// PORTS
// - clk                 in   1       rising-edge clock
// - rst                 in   1       asynchronous reset, active-low
// - stallreq_if         in   1       fetch/instruction memory busy
// - stallreq_id         in   1       load-use hazard; held 1 cycle per bubble
// - stallreq_ex         in   1       multi-cycle EX op busy
// - stallreq_mem        in   1       data memory busy
// - ex_jump_flag        in   1       EX resolved taken jump/branch
// - ex_jump_target      in   ADDR_W  target for ex_jump_flag
// - stall               out  6       [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]reserved
// - flush               out  1       kill contents entering if_id and id_ex this cycle
// - redirect_en         out  1       pc_reg loads redirect_addr this cycle
// - redirect_addr       out  ADDR_W  new PC
// - stat_stall_cycles   out  CNT_W   cycles with stall[0]=1
// - stat_flush_count    out  CNT_W   flushes issued
// BEHAVIOUR
// - stall combinational, highest requesting stage wins:
//   mem->6'b011111, ex->6'b001111, id->6'b000111, if->6'b000011, none->6'b000000; stall[5] always 0.
// - stall[k]&&!stall[k+1] means bubble in downstream register (id_ex behaviour); no extra signal.
// - Jump acceptance: ex_jump_flag counts only when stall[3]==0 (EX instruction advances);
//   while stall[3]=1 the flag is ignored every cycle (EX re-presents it after release).
// - FSM states RUN, PEND (state and pend_addr registered):
//   RUN: accepted jump & stallreq_if==0 -> redirect_en=1, redirect_addr=ex_jump_target, flush=1, stay RUN.
//   RUN: accepted jump & stallreq_if==1 -> flush=1, redirect_en=0, capture target to pend_addr, go PEND.
//   PEND: stallreq_if==1 -> hold; redirect_en=0, flush=0.
//   PEND: stallreq_if==0 -> redirect_en=1, redirect_addr=pend_addr, flush=1, go RUN.
//   PEND and a new accepted jump: cannot occur (flush emptied ID/EX); jump is ignored, no overwrite.
// - Redirect latency 0 cycles from acceptance or from stallreq_if falling; exactly one redirect_en pulse per accepted jump.
// - redirect_addr = 0 when redirect_en=0.
// - Reset (async, any state incl. PEND): state=RUN, pend_addr=0, counters=0; while rst=0 all outputs 0.
// CONFIGURATION
// - STALL_STATS_EN defined: stat_stall_cycles +1 each cycle stall[0]=1;
//   stat_flush_count +1 each cycle flush=1; both wrap modulo 2^CNT_W.
// - STALL_STATS_EN undefined: no counter registers; both stat outputs tied to 0.
// TESTING
// - stallreq_mem=1,stallreq_id=1 -> stall=6'b011111; drop both -> 6'b000000 same cycle.
// - stallreq_id pulse 1 cycle -> stall=6'b000111 for that cycle only; id_ex holds NOP next edge.
// - ex_jump_flag=1,target=32'h0000_1040, no stalls -> redirect_en=1,addr=32'h1040,flush=1 one cycle.
// - jump with stallreq_if=1 for 3 cycles -> flush=1 at accept, redirect_en=0 x3, then one pulse addr=32'h1040.
// - jump while stallreq_mem=1 -> no flush/redirect; on release jump accepted that cycle.
// - rst low while PEND -> outputs 0 at once; after release no redirect issued; stats (if EN) read 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Purpose:
//   Central stall/flush/redirect controller for a 5-stage in-order pipeline.
//   - Merges per-stage stall requests into the 6-bit stall vector consumed by
//     pc_reg, if_id, id_ex, ex_mem and mem_wb. The highest requesting stage
//     wins. Combined with stall[k+1]==0, stall[k]==1 tells the downstream
//     register to take a bubble.
//   - Turns an EX-resolved taken jump/branch into a PC redirect plus a flush.
//   - If fetch is stalled when the jump is accepted, the target is parked
//     (PEND state) and the redirect is issued exactly once when fetch releases.
//   - Holds no pipeline state of its own beyond the redirect FSM.
//
// Configuration macro:
//   STALL_STATS_EN  - when defined, adds wrap-around counters of stalled cycles
//                     and issued flushes; when undefined, the stat outputs are
//                     tied to zero and no counter registers exist.
//
// Ports:
//   clk               in   1       rising-edge clock
//   rst               in   1       asynchronous reset, active-low
//   stallreq_if       in   1       fetch / instruction memory busy
//   stallreq_id       in   1       load-use hazard
//   stallreq_ex       in   1       multi-cycle EX op busy
//   stallreq_mem      in   1       data memory busy
//   ex_jump_flag      in   1       EX resolved a taken jump/branch
//   ex_jump_target    in   ADDR_W  target of that jump
//   stall             out  6       [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]0
//   flush             out  1       kill contents entering if_id and id_ex
//   redirect_en       out  1       pc_reg loads redirect_addr this cycle
//   redirect_addr     out  ADDR_W  new PC (0 when redirect_en is 0)
//   stat_stall_cycles out  CNT_W   cycles with stall[0]=1
//   stat_flush_count  out  CNT_W   flushes issued
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              ex_jump_flag,
    input  logic [ADDR_W-1:0] ex_jump_target,
    output logic [5:0]        stall,
    output logic              flush,
    output logic              redirect_en,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic [CNT_W-1:0]  stat_stall_cycles,
    output logic [CNT_W-1:0]  stat_flush_count
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pend_addr;

    logic [5:0]        w_stall;
    logic              w_jump_acc;
    logic              w_flush;
    logic              w_redir;
    logic [ADDR_W-1:0] w_redir_addr;

    // Priority merge: a stall in a later stage freezes every earlier stage too.
    always_comb begin
        w_stall = 6'b000000;
        if (stallreq_mem)      w_stall = 6'b011111;
        else if (stallreq_ex)  w_stall = 6'b001111;
        else if (stallreq_id)  w_stall = 6'b000111;
        else if (stallreq_if)  w_stall = 6'b000011;
    end

    // The jump only counts when the EX instruction actually advances; while
    // ex_mem is frozen, EX will present the same flag again after release.
    assign w_jump_acc = ex_jump_flag && !w_stall[3];

    // Zero-latency output decode from the current state and inputs.
    always_comb begin
        w_flush      = 1'b0;
        w_redir      = 1'b0;
        w_redir_addr = '0;
        case (r_state)
            RUN: begin
                if (w_jump_acc) begin
                    w_flush = 1'b1;
                    if (!stallreq_if) begin
                        w_redir      = 1'b1;
                        w_redir_addr = ex_jump_target;
                    end
                end
            end
            PEND: begin
                if (!stallreq_if) begin
                    w_flush      = 1'b1;
                    w_redir      = 1'b1;
                    w_redir_addr = r_pend_addr;
                end
            end
            default: ;
        endcase
    end

    // Redirect FSM. A jump seen while PEND is ignored: the flush at acceptance
    // already emptied ID/EX, so the parked target is never overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_pend_addr <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_jump_acc && stallreq_if) begin
                        r_state     <= PEND;
                        r_pend_addr <= ex_jump_target;
                    end
                end
                PEND: begin
                    if (!stallreq_if) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // All outputs are forced low for as long as reset is held.
    assign stall         = rst ? w_stall      : 6'b000000;
    assign flush         = rst ? w_flush      : 1'b0;
    assign redirect_en   = rst ? w_redir      : 1'b0;
    assign redirect_addr = rst ? w_redir_addr : '0;

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall[0]) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush)    r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stat_stall_cycles = r_stall_cnt;
    assign stat_flush_count  = r_flush_cnt;
`else
    assign stat_stall_cycles = '0;
    assign stat_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stallreq_if = 1'b0;
    logic              stallreq_id = 1'b0;
    logic              stallreq_ex = 1'b0;
    logic              stallreq_mem = 1'b0;
    logic              ex_jump_flag = 1'b0;
    logic [ADDR_W-1:0] ex_jump_target = '0;
    logic [5:0]        stall;
    logic              flush;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_addr;
    logic [CNT_W-1:0]  stat_stall_cycles;
    logic [CNT_W-1:0]  stat_flush_count;

    pipeline_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .ex_jump_flag(ex_jump_flag), .ex_jump_target(ex_jump_target),
        .stall(stall), .flush(flush), .redirect_en(redirect_en),
        .redirect_addr(redirect_addr),
        .stat_stall_cycles(stat_stall_cycles), .stat_flush_count(stat_flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  st;
        logic        fl;
        logic        re;
        logic [31:0] ad;
    } exp_t;

    typedef struct packed {
        logic        mem, ex, id, ifr, jf;
        logic [31:0] jt;
        exp_t        e;
    } stim_t;

    exp_t sb[$];
    int checks = 0;
    int passes = 0;
    logic [CNT_W-1:0] m_stall_cnt = '0;
    logic [CNT_W-1:0] m_flush_cnt = '0;

    function automatic stim_t mk(input logic mem, ex, id, ifr, jf, input logic [31:0] jt,
                                 input logic [5:0] st, input logic fl, re, input logic [31:0] ad);
        stim_t s;
        s.mem = mem; s.ex = ex; s.id = id; s.ifr = ifr; s.jf = jf; s.jt = jt;
        s.e.st = st; s.e.fl = fl; s.e.re = re; s.e.ad = ad;
        return s;
    endfunction

    // Apply one cycle of stimulus and record what the outputs must be.
    task automatic drive(input stim_t s);
        stallreq_mem = s.mem; stallreq_ex = s.ex; stallreq_id = s.id;
        stallreq_if = s.ifr; ex_jump_flag = s.jf; ex_jump_target = s.jt;
        sb.push_back(s.e);
    endtask

    // Reference counter update at the end of a cycle that was not in reset.
    task automatic model_stats(input exp_t e);
`ifdef STALL_STATS_EN
        if (e.st[0]) m_stall_cnt = m_stall_cnt + 1'b1;
        if (e.fl)    m_flush_cnt = m_flush_cnt + 1'b1;
`else
        if (e.st[0] === 1'bx) m_stall_cnt = '0;
`endif
    endtask

    task automatic test_reset();
        stallreq_mem = 1'b1; stallreq_if = 1'b1; ex_jump_flag = 1'b1;
        ex_jump_target = 32'h0000_1040;
        #3;
        checks++;
        if ({stall, flush, redirect_en, redirect_addr} !== 40'd0) begin
            $display("FAIL reset_outputs: got stall=%b flush=%b ren=%b addr=%h, want all 0",
                     stall, flush, redirect_en, redirect_addr);
        end else passes++;
        checks++;
        if ({stat_stall_cycles, stat_flush_count} !== 64'd0) begin
            $display("FAIL reset_stats: got %0d/%0d, want 0/0", stat_stall_cycles, stat_flush_count);
        end else passes++;
        @(posedge clk); #1;
        rst = 1'b1;
        stallreq_mem = 1'b0; stallreq_if = 1'b0; ex_jump_flag = 1'b0; ex_jump_target = '0;
    endtask

    task automatic test_stall_merge();
        stim_t s[7];
        exp_t e;
        s[0] = mk(1,0,1,0,0,0, 6'b011111,0,0,0);
        s[1] = mk(0,0,0,0,0,0, 6'b000000,0,0,0);
        s[2] = mk(0,1,0,1,0,0, 6'b001111,0,0,0);
        s[3] = mk(0,0,0,1,0,0, 6'b000011,0,0,0);
        s[4] = mk(0,0,1,1,0,0, 6'b000111,0,0,0);
        s[5] = mk(1,1,1,1,0,0, 6'b011111,0,0,0);
        s[6] = mk(0,0,0,0,0,0, 6'b000000,0,0,0);
        foreach (s[i]) begin
            drive(s[i]);
            #2; e = sb.pop_front();
            checks++;
            if ({stall, flush, redirect_en, redirect_addr} !== e) begin
                $display("FAIL stall_merge[%0d]: got stall=%b fl=%b re=%b ad=%h, want stall=%b fl=%b re=%b ad=%h",
                         i, stall, flush, redirect_en, redirect_addr, e.st, e.fl, e.re, e.ad);
            end else passes++;
            checks++;
            if ({stat_stall_cycles, stat_flush_count} !== {m_stall_cnt, m_flush_cnt}) begin
                $display("FAIL stall_merge_stats[%0d]: got %0d/%0d, want %0d/%0d",
                         i, stat_stall_cycles, stat_flush_count, m_stall_cnt, m_flush_cnt);
            end else passes++;
            model_stats(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_id_pulse();
        stim_t s[3];
        exp_t e;
        s[0] = mk(0,0,1,0,0,0, 6'b000111,0,0,0);
        s[1] = mk(0,0,0,0,0,0, 6'b000000,0,0,0);
        s[2] = mk(0,0,0,0,0,0, 6'b000000,0,0,0);
        foreach (s[i]) begin
            drive(s[i]);
            #2; e = sb.pop_front();
            checks++;
            if ({stall, flush, redirect_en, redirect_addr} !== e) begin
                $display("FAIL id_pulse[%0d]: got stall=%b fl=%b re=%b ad=%h, want stall=%b fl=%b re=%b ad=%h",
                         i, stall, flush, redirect_en, redirect_addr, e.st, e.fl, e.re, e.ad);
            end else passes++;
            model_stats(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump();
        stim_t s[4];
        exp_t e;
        s[0] = mk(0,0,0,0,1,32'h0000_1040, 6'b000000,1,1,32'h0000_1040);
        s[1] = mk(0,0,0,0,0,32'h0000_1040, 6'b000000,0,0,0);
        // load-use stall does not freeze ex_mem, so the jump is still accepted
        s[2] = mk(0,0,1,0,1,32'hABCD_0008, 6'b000111,1,1,32'hABCD_0008);
        s[3] = mk(0,0,0,0,0,32'hABCD_0008, 6'b000000,0,0,0);
        foreach (s[i]) begin
            drive(s[i]);
            #2; e = sb.pop_front();
            checks++;
            if ({stall, flush, redirect_en, redirect_addr} !== e) begin
                $display("FAIL jump[%0d]: got stall=%b fl=%b re=%b ad=%h, want stall=%b fl=%b re=%b ad=%h",
                         i, stall, flush, redirect_en, redirect_addr, e.st, e.fl, e.re, e.ad);
            end else passes++;
            checks++;
            if ({stat_stall_cycles, stat_flush_count} !== {m_stall_cnt, m_flush_cnt}) begin
                $display("FAIL jump_stats[%0d]: got %0d/%0d, want %0d/%0d",
                         i, stat_stall_cycles, stat_flush_count, m_stall_cnt, m_flush_cnt);
            end else passes++;
            model_stats(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump_pend();
        stim_t s[6];
        exp_t e;
        s[0] = mk(0,0,0,1,1,32'h0000_1040, 6'b000011,1,0,0);
        // a second jump while parked must not replace the parked target
        s[1] = mk(0,0,0,1,1,32'h0000_2000, 6'b000011,0,0,0);
        s[2] = mk(0,0,0,1,0,32'h0000_0000, 6'b000011,0,0,0);
        s[3] = mk(0,0,0,0,0,32'h0000_0000, 6'b000000,1,1,32'h0000_1040);
        s[4] = mk(0,0,0,0,0,32'h0000_0000, 6'b000000,0,0,0);
        s[5] = mk(0,0,0,1,0,32'h0000_0000, 6'b000011,0,0,0);
        foreach (s[i]) begin
            drive(s[i]);
            #2; e = sb.pop_front();
            checks++;
            if ({stall, flush, redirect_en, redirect_addr} !== e) begin
                $display("FAIL jump_pend[%0d]: got stall=%b fl=%b re=%b ad=%h, want stall=%b fl=%b re=%b ad=%h",
                         i, stall, flush, redirect_en, redirect_addr, e.st, e.fl, e.re, e.ad);
            end else passes++;
            checks++;
            if ({stat_stall_cycles, stat_flush_count} !== {m_stall_cnt, m_flush_cnt}) begin
                $display("FAIL jump_pend_stats[%0d]: got %0d/%0d, want %0d/%0d",
                         i, stat_stall_cycles, stat_flush_count, m_stall_cnt, m_flush_cnt);
            end else passes++;
            model_stats(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump_mem_stall();
        stim_t s[4];
        exp_t e;
        s[0] = mk(1,0,0,0,1,32'h0000_1040, 6'b011111,0,0,0);
        s[1] = mk(0,1,0,0,1,32'h0000_1040, 6'b001111,0,0,0);
        s[2] = mk(0,0,0,0,1,32'h0000_1040, 6'b000000,1,1,32'h0000_1040);
        s[3] = mk(0,0,0,0,0,32'h0000_0000, 6'b000000,0,0,0);
        foreach (s[i]) begin
            drive(s[i]);
            #2; e = sb.pop_front();
            checks++;
            if ({stall, flush, redirect_en, redirect_addr} !== e) begin
                $display("FAIL jump_mem_stall[%0d]: got stall=%b fl=%b re=%b ad=%h, want stall=%b fl=%b re=%b ad=%h",
                         i, stall, flush, redirect_en, redirect_addr, e.st, e.fl, e.re, e.ad);
            end else passes++;
            model_stats(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_pend();
        stim_t s[2];
        exp_t e;
        s[0] = mk(0,0,0,1,1,32'h0000_1040, 6'b000011,1,0,0);
        s[1] = mk(0,0,0,1,0,32'h0000_0000, 6'b000011,0,0,0);
        foreach (s[i]) begin
            drive(s[i]);
            #2; e = sb.pop_front();
            checks++;
            if ({stall, flush, redirect_en, redirect_addr} !== e) begin
                $display("FAIL reset_pend_enter[%0d]: got stall=%b fl=%b re=%b ad=%h, want stall=%b fl=%b re=%b ad=%h",
                         i, stall, flush, redirect_en, redirect_addr, e.st, e.fl, e.re, e.ad);
            end else passes++;
            model_stats(e);
            @(posedge clk); #1;
        end
        // Now parked in PEND; assert reset mid-cycle with stall requests active.
        stallreq_mem = 1'b1; stallreq_if = 1'b1;
        #2; rst = 1'b0; #1;
        m_stall_cnt = '0; m_flush_cnt = '0;
        checks++;
        if ({stall, flush, redirect_en, redirect_addr} !== 40'd0) begin
            $display("FAIL reset_pend_async: got stall=%b fl=%b re=%b ad=%h, want all 0",
                     stall, flush, redirect_en, redirect_addr);
        end else passes++;
        checks++;
        if ({stat_stall_cycles, stat_flush_count} !== 64'd0) begin
            $display("FAIL reset_pend_stats: got %0d/%0d, want 0/0", stat_stall_cycles, stat_flush_count);
        end else passes++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        s[0] = mk(0,0,0,0,0,32'h0000_0000, 6'b000000,0,0,0);
        s[1] = mk(0,0,0,0,0,32'h0000_0000, 6'b000000,0,0,0);
        foreach (s[i]) begin
            drive(s[i]);
            #2; e = sb.pop_front();
            checks++;
            if ({stall, flush, redirect_en, redirect_addr} !== e) begin
                $display("FAIL reset_pend_after[%0d]: got stall=%b fl=%b re=%b ad=%h, want stall=%b fl=%b re=%b ad=%h",
                         i, stall, flush, redirect_en, redirect_addr, e.st, e.fl, e.re, e.ad);
            end else passes++;
            checks++;
            if ({stat_stall_cycles, stat_flush_count} !== {m_stall_cnt, m_flush_cnt}) begin
                $display("FAIL reset_pend_after_stats[%0d]: got %0d/%0d, want %0d/%0d",
                         i, stat_stall_cycles, stat_flush_count, m_stall_cnt, m_flush_cnt);
            end else passes++;
            model_stats(e);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_stall_merge();
        test_id_pulse();
        test_jump();
        test_jump_pend();
        test_jump_mem_stall();
        test_reset_pend();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, passed=%0d of %0d", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
